q2_sequencer: RTL
=================

Q2_SEQUENCER -- requirements
Module: q2_sequencer

Interface
REQ-001 SHALL have parameter WORD_BITS, default 12, meaning data bus width and the number of bit-serial ALU shift states.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flop count of each switch synchronizer.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 run_sw  input  1  front-panel run switch, asynchronous level.
REQ-006 step_sw  input  1  front-panel single-step switch, asynchronous level.
REQ-007 dbus  input  WORD_BITS  data bus carrying the instruction word during fetch.
REQ-008 s0, s1, s2, s3  output  1 each  registered state code, s0 = LSB.
REQ-009 ws  output  1  registered write-strobe phase of the current state.
REQ-010 op2, op3, op4, op5  output  1 each  registered latched opcode bits.
REQ-011 running  output  1  high while the sequencer is advancing.

Function
REQ-012 Each state SHALL last exactly two clocks: phase A (ws=0), then phase B (ws=1); the state advances on the edge ending phase B.
REQ-013 State codes SHALL be: 0 FETCH, 1 LOAD, 2 DEREF, 3 EXEC, 4..15 ALU shift states; 12 ALU states equal WORD_BITS at default.
REQ-014 On the edge ending FETCH phase B, op5..op2 SHALL load dbus[11:8]; op bits SHALL hold otherwise.
REQ-015 The transition FETCH->LOAD SHALL always be taken.
REQ-016 LOAD SHALL go to DEREF when op2=1, else directly to EXEC.
REQ-017 DEREF SHALL go to EXEC.
REQ-018 EXEC SHALL go to state 4 when op5=0, else to FETCH.
REQ-019 ALU states SHALL increment 4->5->...->15; state 15 SHALL wrap to FETCH.
REQ-020 Instruction length in clocks SHALL be: op5=1,op2=0 -> 6; op5=1,op2=1 -> 8; op5=0,op2=0 -> 30; op5=0,op2=1 -> 32.
REQ-021 run_sw and step_sw SHALL each pass through a SYNC_STAGES-flop synchronizer before use; step SHALL act on the synchronized rising edge only.
REQ-022 Halted position SHALL be FETCH phase A with running=0; while halted, s, ws and op SHALL hold.
REQ-023 From halt, synchronized run_sw=1 SHALL set running=1 on the next edge; advancing starts in the same cycle running is 1.
REQ-024 From halt, a step edge with run_sw=0 SHALL run exactly one instruction, then re-enter halt at FETCH phase A.
REQ-025 Dropping run_sw mid-instruction SHALL complete the current instruction and halt at the next FETCH phase A; there is no mid-instruction stop.
REQ-026 A step edge while running SHALL be ignored.
REQ-027 Simultaneous run rising and step edge SHALL be treated as run.
REQ-028 An opcode latched in FETCH SHALL steer all transitions of that instruction, even if dbus changes.

Reset
REQ-029 While rst_n=0: s3..s0=0000, ws=0, op5..op2=0000, running=0, synchronizers cleared, step edge detector cleared.
REQ-030 Reset asserted mid-instruction SHALL abort immediately to the halted FETCH phase A, with no write-strobe pulse generated.
REQ-031 After rst_n rises, the first advance SHALL need synchronized run_sw=1 or a step edge; a switch already held at reset release counts as a rising edge after synchronization.

Structure
REQ-032 State code constants (FETCH, LOAD, DEREF, EXEC, ALU_FIRST=4, ALU_LAST=15) and the opcode bit positions in dbus SHALL live in the shared package q2_pkg.
REQ-033 One sub-module, q2_sync (parameterized SYNC_STAGES, active-low async reset), SHALL be instantiated once per switch.
REQ-034 The next-state decode SHALL be a single combinational block; all outputs SHALL come directly from flops.

Verification
REQ-035 Reset then run_sw=1, dbus[11:8]=0b1000 (op5=1, op2=0) -> s sequence 0,1,3, each held 2 clocks with ws 0 then 1; returns to 0 after 6 clocks.
REQ-036 dbus[11:8]=0b0001 (op5=0, op2=1), running -> s visits 0,1,2,3,4..15 in order, 32 clocks per instruction, ws toggles every clock.
REQ-037 Halted, pulse step_sw with dbus[11:8]=0b1001 -> one 8-clock instruction, then running=0 at s=0, ws=0; a second step repeats it.
REQ-038 run_sw dropped while s=6 -> states 7..15 complete, then halt at s=0 phase A; op bits retain the last opcode.
REQ-039 rst_n pulled low at s=9, ws=1 -> all outputs 0 asynchronously, before the next clock edge.
REQ-040 step_sw toggled while running, and dbus changed during EXEC -> instruction length unchanged, no extra instruction executed.

Source files
------------

// File: rtl/q2_pkg.sv
// Shared constants for the Q2 front-panel sequencer: state codes and the
// opcode field position inside the instruction word.
package q2_pkg;

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] LOAD      = 4'd1;
    localparam logic [3:0] DEREF     = 4'd2;
    localparam logic [3:0] EXEC      = 4'd3;
    localparam logic [3:0] ALU_FIRST = 4'd4;
    localparam logic [3:0] ALU_LAST  = 4'd15;

    // op2 sits at OP_LSB, op5 at OP_MSB
    localparam int unsigned OP_LSB = 8;
    localparam int unsigned OP_MSB = 11;

endpackage

// File: rtl/q2_sync.sv
// Multi-flop synchronizer for one asynchronous front-panel switch level.
module q2_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain[0] <= raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign clean = chain[SYNC_STAGES-1];

endmodule

// File: rtl/q2_sequencer.sv
// Q2 instruction sequencer: two-phase states (ws low then high), opcode
// latched in FETCH, run/single-step control from synchronized switches.
module q2_sequencer #(
    parameter int unsigned WORD_BITS   = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_sw,
    input  logic                 step_sw,
    input  logic [WORD_BITS-1:0] dbus,
    output logic                 s0,
    output logic                 s1,
    output logic                 s2,
    output logic                 s3,
    output logic                 ws,
    output logic                 op2,
    output logic                 op3,
    output logic                 op4,
    output logic                 op5,
    output logic                 running
);

    import q2_pkg::*;

    logic       run_s;
    logic       step_s;
    logic       step_prev;
    logic       step_edge;
    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       phase;
    logic       phase_nxt;
    logic [3:0] op;
    logic [3:0] op_nxt;
    logic       run_flag;
    logic       run_flag_nxt;
    logic       unused_dbus;

    q2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (run_sw),
        .clean (run_s)
    );

    q2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (step_sw),
        .clean (step_s)
    );

    assign step_edge   = step_s & ~step_prev;
    assign unused_dbus = ^dbus;

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        op_nxt       = op;
        run_flag_nxt = run_flag;
        if (!run_flag) begin
            if (run_s || step_edge) begin
                run_flag_nxt = 1'b1;
            end
        end else if (!phase) begin
            phase_nxt = 1'b1;
        end else begin
            phase_nxt = 1'b0;
            case (state)
                FETCH: begin
                    state_nxt = LOAD;
                    op_nxt    = dbus[OP_MSB:OP_LSB];
                end
                LOAD:     state_nxt = op[0] ? DEREF : EXEC;
                DEREF:    state_nxt = EXEC;
                EXEC:     state_nxt = op[3] ? FETCH : ALU_FIRST;
                ALU_LAST: state_nxt = FETCH;
                default:  state_nxt = state + 4'd1;
            endcase
            // Run/step is only re-evaluated at an instruction boundary
            if (state_nxt == FETCH) begin
                run_flag_nxt = run_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            phase     <= 1'b0;
            op        <= '0;
            run_flag  <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            op        <= op_nxt;
            run_flag  <= run_flag_nxt;
            step_prev <= step_s;
        end
    end

    assign {s3, s2, s1, s0}     = state;
    assign ws                   = phase;
    assign {op5, op4, op3, op2} = op;
    assign running              = run_flag;

endmodule
